// File: rtl/blink_pattern_seq_if.sv
// Bundle between the blinker stage and the LED pattern sequencer.
// master drives the step/mode/control/pattern inputs; slave (the sequencer) drives the LED and status outputs.
interface blink_pattern_seq_if #(
  parameter int PLEN     = 8,
  parameter int PWM_BITS = 4
);
  localparam int SW = $clog2(PLEN);

  logic                tick_in;
  logic                mode_in;
  logic                enable;
  logic                hold;
  logic [PLEN-1:0]     pat_in;
  logic                pat_load;
  logic [PWM_BITS-1:0] duty;
  logic                led_out;
  logic [SW-1:0]       step_idx;
  logic                wrap_flg;
  logic                busy;

  modport master (
    output tick_in, mode_in, enable, hold, pat_in, pat_load, duty,
    input  led_out, step_idx, wrap_flg, busy
  );

  modport slave (
    input  tick_in, mode_in, enable, hold, pat_in, pat_load, duty,
    output led_out, step_idx, wrap_flg, busy
  );
endinterface

// File: rtl/blink_pattern_seq.sv
// Steps through a programmable on/off pattern, one step per blinker pulse, and drives a PWM-dimmed LED.
// A pattern loaded while running is held in a shadow register and takes effect on the next wrap.
module blink_pattern_seq #(
  parameter int PLEN     = 8,
  parameter int PWM_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  blink_pattern_seq_if.slave bus
);
  localparam int SW = $clog2(PLEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [SW-1:0] LAST_STEP = SW'(PLEN - 1);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [SW-1:0]       step_idx;
  logic [SW-1:0]       step_nxt;
  logic [PLEN-1:0]     pat_active;
  logic [PLEN-1:0]     pat_shadow;
  logic [PLEN-1:0]     pat_nxt;
  logic                load_pend;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                led_out;
  logic                wrap_flg;
  logic                busy;
  logic                step_en;
  logic                wrap_now;
  logic                led_bit;
  logic                pwm_on;

  // Disabling takes priority over hold in both active states.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.enable) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!bus.enable)   state_nxt = ST_IDLE;
        else if (bus.hold) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!bus.enable)    state_nxt = ST_IDLE;
        else if (!bus.hold) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    step_en  = (state == ST_RUN) && bus.tick_in;
    wrap_now = step_en && (step_idx == LAST_STEP);

    step_nxt = step_idx;
    if ((state == ST_IDLE) && bus.enable)
      step_nxt = '0;
    else if (step_en)
      step_nxt = wrap_now ? '0 : step_idx + SW'(1);

    // A load on the wrap tick itself bypasses the shadow so it lands on this lap.
    pat_nxt = pat_active;
    if (state == ST_IDLE) begin
      if (bus.pat_load) pat_nxt = bus.pat_in;
    end else if (wrap_now) begin
      if (bus.pat_load)   pat_nxt = bus.pat_in;
      else if (load_pend) pat_nxt = pat_shadow;
    end

    led_bit = pat_nxt[step_nxt] ^ bus.mode_in;
    pwm_on  = (pwm_cnt < bus.duty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      step_idx   <= '0;
      pat_active <= '0;
      pat_shadow <= '0;
      load_pend  <= 1'b0;
      pwm_cnt    <= '0;
      led_out    <= 1'b0;
      wrap_flg   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      step_idx   <= step_nxt;
      pat_active <= pat_nxt;
      wrap_flg   <= wrap_now;
      pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
      led_out    <= (state != ST_IDLE) && led_bit && pwm_on;
      busy       <= (state_nxt != ST_IDLE);
      if (bus.pat_load) pat_shadow <= bus.pat_in;
      if (state != ST_IDLE) begin
        if (wrap_now)          load_pend <= 1'b0;
        else if (bus.pat_load) load_pend <= 1'b1;
      end
    end
  end

  assign bus.led_out  = led_out;
  assign bus.step_idx = step_idx;
  assign bus.wrap_flg = wrap_flg;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_blink_pattern_seq.sv
// Directed bench for blink_pattern_seq: a stepping vector table plus hand-written sequences
// for reset, shadow load, hold/enable, PWM/mode and the back-to-back wrap corner.
module tb_blink_pattern_seq;
  localparam int PLEN     = 8;
  localparam int PWM_BITS = 4;

  typedef struct {
    logic       tick;
    logic       pat_load;
    logic [7:0] pat_in;
    logic       hold;
    logic       enable;
    logic       mode;
    logic [3:0] duty;
    logic [2:0] exp_step;
    logic       exp_wrap;
    logic       exp_bit;
    logic       exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] pwm_ref = 4'd0;
  logic       pwm_on_exp = 1'b0;

  always #5 clk = ~clk;

  blink_pattern_seq_if #(.PLEN(PLEN), .PWM_BITS(PWM_BITS)) bus ();

  blink_pattern_seq #(.PLEN(PLEN), .PWM_BITS(PWM_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assert property (@(posedge clk) disable iff (rst) bus.wrap_flg |=> !bus.wrap_flg)
    else begin
      errors++;
      $display("[TB] FAIL wrap_flg_single: wrap_flg high two cycles running at %0t", $time);
    end

  function automatic vec_t mk(input logic t, input logic pl, input logic [7:0] pi,
                              input logic h, input logic en, input logic m, input logic [3:0] d,
                              input logic [2:0] s, input logic w, input logic b, input logic bz);
    vec_t v;
    v.tick = t;  v.pat_load = pl; v.pat_in = pi; v.hold = h; v.enable = en; v.mode = m;
    v.duty = d;  v.exp_step = s;  v.exp_wrap = w; v.exp_bit = b; v.exp_busy = bz;
    return v;
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The PWM expectation is taken from the counter value before the edge, as the DUT does.
  task automatic clk_edge();
    pwm_on_exp = (pwm_ref < bus.duty);
    @(posedge clk);
    pwm_ref = rst ? 4'd0 : pwm_ref + 4'd1;
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.tick_in  = v.tick;
    bus.pat_load = v.pat_load;
    bus.pat_in   = v.pat_in;
    bus.hold     = v.hold;
    bus.enable   = v.enable;
    bus.mode_in  = v.mode;
    bus.duty     = v.duty;
    clk_edge();
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    check1({tag, ".step"}, 32'(bus.step_idx), 32'(v.exp_step));
    check1({tag, ".wrap"}, 32'(bus.wrap_flg), 32'(v.exp_wrap));
    check1({tag, ".led"},  32'(bus.led_out),  32'(v.exp_bit & pwm_on_exp));
    check1({tag, ".busy"}, 32'(bus.busy),     32'(v.exp_busy));
  endtask

  task automatic cycle(input string tag, input vec_t v);
    applyStimulus(v);
    checkOutput(tag, v);
  endtask

  initial begin
    vec_t       tbl [8];
    vec_t       v;
    logic [7:0] pat_a;
    logic [7:0] pat_c;
    logic [7:0] pat_d;
    int         led_cnt;

    pat_a = 8'hA5;
    pat_c = 8'h3C;
    pat_d = 8'h81;
    tbl[0] = mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'd1, 0, 0, 1);
    tbl[1] = mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'd2, 0, 1, 1);
    tbl[2] = mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'd3, 0, 0, 1);
    tbl[3] = mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'd4, 0, 0, 1);
    tbl[4] = mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'd5, 0, 1, 1);
    tbl[5] = mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'd6, 0, 0, 1);
    tbl[6] = mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'd7, 0, 1, 1);
    tbl[7] = mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'd0, 1, 1, 1);

    bus.tick_in = 1'b0; bus.pat_load = 1'b0; bus.pat_in = '0; bus.hold = 1'b0;
    bus.enable = 1'b0;  bus.mode_in = 1'b0;  bus.duty = 4'hF;
    rst = 1'b1;
    repeat (2) clk_edge();
    rst = 1'b0;

    $display("[TB] reset amid activity");
    bus.enable = 1'b1;
    clk_edge();
    bus.tick_in = 1'b1;
    repeat (3) clk_edge();
    rst = 1'b1;
    for (int i = 0; i < 3; i++)
      cycle($sformatf("rst%0d", i), mk(1, 1, 8'hFF, 0, 1, 0, 4'hF, 3'd0, 0, 0, 0));
    rst = 1'b0;
    cycle("rst_after", mk(0, 0, 8'h00, 0, 0, 0, 4'hF, 3'd0, 0, 0, 0));

    $display("[TB] stepping table");
    cycle("load_idle", mk(0, 1, pat_a, 0, 0, 0, 4'hF, 3'd0, 0, 0, 0));
    cycle("start",     mk(0, 0, 8'h00, 0, 1, 0, 4'hF, 3'd0, 0, 0, 1));
    for (int i = 0; i < 8; i++) begin
      cycle($sformatf("tbl%0d", i), tbl[i]);
      v = tbl[i];
      v.tick = 1'b0;
      v.exp_wrap = 1'b0;
      for (int k = 0; k < 4; k++)
        cycle($sformatf("tbl%0d_gap%0d", i, k), v);
    end

    $display("[TB] shadow load");
    for (int s = 1; s <= 3; s++)
      cycle($sformatf("sh_step%0d", s), mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'(s), 0, pat_a[s], 1));
    cycle("sh_load", mk(0, 1, 8'hFF, 0, 1, 0, 4'hF, 3'd3, 0, pat_a[3], 1));
    for (int s = 4; s <= 7; s++)
      cycle($sformatf("sh_old%0d", s), mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'(s), 0, pat_a[s], 1));
    cycle("sh_wrap", mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'd0, 1, 1, 1));
    for (int s = 1; s <= 7; s++)
      cycle($sformatf("sh_new%0d", s), mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'(s), 0, 1, 1));

    $display("[TB] hold and enable");
    cycle("hold_enter", mk(0, 0, 8'h00, 1, 1, 0, 4'hF, 3'd7, 0, 1, 1));
    for (int k = 0; k < 4; k++)
      cycle($sformatf("hold_tick%0d", k), mk(1, 0, 8'h00, 1, 1, 0, 4'hF, 3'd7, 0, 1, 1));
    cycle("hold_disable", mk(0, 0, 8'h00, 1, 0, 0, 4'hF, 3'd7, 0, 1, 0));
    cycle("idle_led0",    mk(1, 0, 8'h00, 1, 0, 0, 4'hF, 3'd7, 0, 0, 0));
    cycle("idle_led1",    mk(1, 0, 8'h00, 0, 0, 0, 4'hF, 3'd7, 0, 0, 0));

    $display("[TB] pwm and mode");
    cycle("pwm_start", mk(0, 0, 8'h00, 0, 1, 0, 4'd4, 3'd0, 0, 0, 1));
    led_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      cycle($sformatf("pwm%0d", k), mk(0, 0, 8'h00, 0, 1, 0, 4'd4, 3'd0, 0, 1, 1));
      led_cnt += int'(bus.led_out);
    end
    check1("pwm_duty4_count", 32'(led_cnt), 32'd4);
    cycle("mode_on", mk(0, 0, 8'h00, 0, 1, 1, 4'd4, 3'd0, 0, 0, 1));
    led_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      cycle($sformatf("mode%0d", k), mk(0, 0, 8'h00, 0, 1, 1, 4'd4, 3'd0, 0, 0, 1));
      led_cnt += int'(bus.led_out);
    end
    check1("mode_inv_count", 32'(led_cnt), 32'd0);

    $display("[TB] back-to-back wrap with load");
    cycle("bb_mode_off", mk(0, 0, 8'h00, 0, 1, 0, 4'hF, 3'd0, 0, 1, 1));
    for (int s = 1; s <= 7; s++)
      cycle($sformatf("bb_step%0d", s), mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'(s), 0, 1, 1));
    cycle("bb_wrap", mk(1, 1, pat_c, 0, 1, 0, 4'hF, 3'd0, 1, pat_c[0], 1));
    for (int s = 1; s <= 5; s++)
      cycle($sformatf("bb_new%0d", s), mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'(s), 0, pat_c[s], 1));

    $display("[TB] last shadow load wins");
    cycle("lw_load1", mk(0, 1, 8'h7E, 0, 1, 0, 4'hF, 3'd5, 0, pat_c[5], 1));
    cycle("lw_load2", mk(0, 1, pat_d, 0, 1, 0, 4'hF, 3'd5, 0, pat_c[5], 1));
    for (int s = 6; s <= 7; s++)
      cycle($sformatf("lw_old%0d", s), mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'(s), 0, pat_c[s], 1));
    cycle("lw_wrap",  mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'd0, 1, pat_d[0], 1));
    cycle("lw_step1", mk(1, 0, 8'h00, 0, 1, 0, 4'hF, 3'd1, 0, pat_d[1], 1));
    cycle("lw_idle",  mk(0, 0, 8'h00, 0, 1, 0, 4'hF, 3'd1, 0, pat_d[1], 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
